// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network readout blocks.
package snn_pkg;

  localparam int DEF_CNT_WIDTH    = 8;
  localparam int DEF_WINDOW_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_HOLD   = 2'd3
  } dec_state_e;

  // Largest value an unsigned counter of the given width can hold.
  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// Per-class spike counter: synchronous clear, increment that sticks at full scale.
module spike_sat_counter
  import snn_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(sat_max(CNT_WIDTH));

  logic [CNT_WIDTH-1:0] r_count;

  // Count register; holds at CNT_MAX instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate-coded readout: windowed per-class spike counts, then a sequential argmax.
// Optional feature macro: SPIKE_DECODER_AUTO_RESTART_EN (back-to-back windows without start).
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int  NUM_CLASSES  = 3,
  parameter int  CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int  WINDOW_WIDTH = DEF_WINDOW_WIDTH,
  localparam int IDX_WIDTH    = $clog2(NUM_CLASSES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [WINDOW_WIDTH-1:0]        window_len,
  input  logic [NUM_CLASSES-1:0]         spikes_in,
  input  logic                           spikes_valid,
  output logic                           busy,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [IDX_WIDTH-1:0]           winner_class,
  output logic [CNT_WIDTH-1:0]           winner_count,
  output logic                           tie,
  output logic [NUM_CLASSES*CNT_WIDTH-1:0] spike_counts
);

  dec_state_e              r_state, w_next_state;
  logic [WINDOW_WIDTH-1:0] r_window_len, r_sample_cnt, w_sample_next;
  logic [IDX_WIDTH-1:0]    r_scan_idx, r_winner;
  logic [CNT_WIDTH-1:0]    r_best, w_scan_count;
  logic                    r_tie, r_busy, r_result_valid;
  logic                    w_clear, w_count_en, w_last_sample, w_last_idx, w_handshake;
  logic [CNT_WIDTH-1:0]    w_counts [NUM_CLASSES];

  assign w_handshake   = r_result_valid & result_ready;
  assign w_sample_next = r_sample_cnt + WINDOW_WIDTH'(1);
  assign w_count_en    = (r_state == ST_ACCUM) && spikes_valid;
  assign w_last_sample = w_count_en && (w_sample_next == r_window_len);
  assign w_last_idx    = (r_scan_idx == IDX_WIDTH'(NUM_CLASSES - 1));

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
    spike_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_clear),
      .i_inc   (w_count_en & spikes_in[g]),
      .o_count (w_counts[g])
    );
    assign spike_counts[g*CNT_WIDTH +: CNT_WIDTH] = w_counts[g];
  end

  // Select the counter under inspection by the argmax scan.
  always_comb begin
    w_scan_count = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (r_scan_idx == IDX_WIDTH'(i)) begin
        w_scan_count = w_counts[i];
      end else begin
        w_scan_count = w_scan_count;
      end
    end
  end

  // Next-state logic and window-clear strobe.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_next_state = (window_len == '0) ? ST_ARGMAX : ST_ACCUM;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_last_sample) w_next_state = ST_ARGMAX;
        else               w_next_state = ST_ACCUM;
      end
      ST_ARGMAX: begin
        if (w_last_idx) w_next_state = ST_HOLD;
        else            w_next_state = ST_ARGMAX;
      end
      ST_HOLD: begin
        if (w_handshake) begin
`ifdef SPIKE_DECODER_AUTO_RESTART_EN
          w_clear      = 1'b1;
          w_next_state = (r_window_len == '0) ? ST_ARGMAX : ST_ACCUM;
`else
          w_next_state = ST_IDLE;
`endif
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_busy         <= (w_next_state != ST_IDLE);
      r_result_valid <= (w_next_state == ST_HOLD);
    end
  end

  // Window bookkeeping and argmax scan; lowest index keeps the win on equal counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window_len <= '0;
      r_sample_cnt <= '0;
      r_scan_idx   <= '0;
      r_best       <= '0;
      r_winner     <= '0;
      r_tie        <= 1'b0;
    end else if (w_clear) begin
      r_sample_cnt <= '0;
      r_scan_idx   <= '0;
      r_best       <= '0;
      r_winner     <= '0;
      r_tie        <= 1'b0;
      if (r_state == ST_IDLE) r_window_len <= window_len;
    end else if (w_count_en) begin
      r_sample_cnt <= w_sample_next;
    end else if (r_state == ST_ARGMAX) begin
      r_scan_idx <= w_last_idx ? '0 : r_scan_idx + IDX_WIDTH'(1);
      if (r_scan_idx == '0) begin
        r_best   <= w_scan_count;
        r_winner <= '0;
        r_tie    <= 1'b0;
      end else if (w_scan_count > r_best) begin
        r_best   <= w_scan_count;
        r_winner <= r_scan_idx;
        r_tie    <= 1'b0;
      end else if (w_scan_count == r_best) begin
        r_tie <= 1'b1;
      end
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign winner_class = r_winner;
  assign winner_count = r_best;
  assign tie          = r_tie;

endmodule
